// File: rtl/dnn_neuron_engine_if.sv
// Register-write / compute-control bus of the neuron engine.
//   master (CPU side): drives wr_en, wr_sel, wr_idx, wr_data, start;
//                      observes busy, hold, done, y.
//   slave (engine)   : the reverse.
// IDX_W is derived from N_IN so engine and bus always agree on index width.
interface dnn_neuron_engine_if #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 8
);
  localparam int IDX_W = $clog2(N_IN);

  logic              wr_en;
  logic [1:0]        wr_sel;   // 0 x[idx], 1 w[idx], 2 bias, 3 len
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              hold;
  logic              done;
  logic [DATA_W-1:0] y;

  modport master (output wr_en, wr_sel, wr_idx, wr_data, start,
                  input  busy, hold, done, y);
  modport slave  (input  wr_en, wr_sel, wr_idx, wr_data, start,
                  output busy, hold, done, y);
endinterface

// File: rtl/dnn_neuron_engine.sv
// Single fixed-point neuron: y = act(sat((bias<<F + sum x[k]*w[k]) >>> F)).
// One MAC per cycle over the active channels, then ACT, then DONE which
// registers y and a one-cycle done pulse (visible the cycle after DONE).
// Ports: clk, rst (async, active-low), bus (dnn_neuron_engine_if.slave).
// Build option: define DNN_RELU_EN for ReLU activation; otherwise identity.
module dnn_neuron_engine #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 8,
  parameter int FRAC_W = 8
) (
  input logic                clk,
  input logic                rst,
  dnn_neuron_engine_if.slave bus
);
  localparam int IDX_W = $clog2(N_IN);
  localparam int ACC_W = 2*DATA_W + IDX_W + 1;
  localparam int LEN_W = IDX_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;
  state_t state, state_nxt;

  logic signed [DATA_W-1:0]   x_r [N_IN];
  logic signed [DATA_W-1:0]   w_r [N_IN];
  logic signed [DATA_W-1:0]   bias_r, bias_eff, r_sat, act;
  logic        [LEN_W-1:0]    len_r, cnt, n_act;
  logic        [IDX_W-1:0]    cidx;
  logic signed [ACC_W-1:0]    acc, acc_sh;
  logic signed [2*DATA_W-1:0] prod;
  logic                       last, wr_ok, done_r;
  logic        [DATA_W-1:0]   y_r;

  // len 0 or out-of-range selects all channels
  assign n_act = (len_r == '0 || len_r > LEN_W'(N_IN)) ? LEN_W'(N_IN) : len_r;
  assign last  = (cnt == n_act - LEN_W'(1));
  assign cidx  = cnt[IDX_W-1:0];
  assign prod  = x_r[cidx] * w_r[cidx];
  assign wr_ok = (int'(bus.wr_idx) < N_IN);
  // a bias written in the start cycle must seed the accumulator
  assign bias_eff = (bus.wr_en && bus.wr_sel == 2'd2) ? $signed(bus.wr_data) : bias_r;

  always_comb begin
    acc_sh = acc >>> FRAC_W;
    if (acc_sh > SAT_MAX)      r_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_sh < SAT_MIN) r_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                       r_sat = acc_sh[DATA_W-1:0];
`ifdef DNN_RELU_EN
    act = r_sat[DATA_W-1] ? '0 : r_sat;
`else
    act = r_sat;
`endif
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = MAC;
      MAC:  if (last)      state_nxt = ACT;
      ACT:                 state_nxt = DONE;
      DONE:                state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; hold is forced low while reset is asserted
  always_comb begin
    bus.busy = (state != IDLE);
    bus.hold = rst & ((state != IDLE) | (bus.start & (state == IDLE)));
  end

  assign bus.done = done_r;
  assign bus.y    = y_r;

  // datapath; writes and start are only honoured in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) begin
        x_r[i] <= '0;
        w_r[i] <= '0;
      end
      bias_r <= '0;
      len_r  <= '0;
      acc    <= '0;
      cnt    <= '0;
      y_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.wr_en) begin
            case (bus.wr_sel)
              2'd0: if (wr_ok) x_r[bus.wr_idx] <= $signed(bus.wr_data);
              2'd1: if (wr_ok) w_r[bus.wr_idx] <= $signed(bus.wr_data);
              2'd2: bias_r <= $signed(bus.wr_data);
              default: len_r <= bus.wr_data[LEN_W-1:0];
            endcase
          end
          if (bus.start) begin
            acc <= ACC_W'(bias_eff) <<< FRAC_W;
            cnt <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          cnt <= cnt + LEN_W'(1);
        end
        DONE: y_r <= act;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/dnn_neuron_engine.md
DNN_NEURON_ENGINE -- requirements
Module: dnn_neuron_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of inputs, weights, bias and result, signed two's complement.
REQ-002 SHALL have parameter N_IN, default 8: number of input channels, 2..64.
REQ-003 SHALL have parameter FRAC_W, default 8: fractional bits of the fixed-point format, less than DATA_W.
REQ-004 SHALL have localparams IDX_W = $clog2(N_IN) and ACC_W = 2*DATA_W + IDX_W + 1.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  register write strobe.
REQ-008 wr_sel  input  2  write target: 0 = x[idx], 1 = w[idx], 2 = bias, 3 = len.
REQ-009 wr_idx  input  IDX_W  channel index for x and w writes.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 start  input  1  compute request.
REQ-012 busy  output  1  engine computing.
REQ-013 hold  output  1  CPU PC-stall request.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 y  output  DATA_W  neuron result, held until the next completion.

Function
REQ-016 SHALL implement FSM states IDLE, MAC, ACT, DONE.
REQ-017 In IDLE with wr_en=1, SHALL write the selected register on the clock edge.
REQ-018 SHALL ignore x/w writes with wr_idx >= N_IN.
REQ-019 SHALL interpret len as its low IDX_W+1 bits; len = 0 or len > N_IN SHALL mean N_IN active channels.
REQ-020 In IDLE with start=1, SHALL go to MAC, clear the accumulator to bias <<< FRAC_W (sign-extended to ACC_W), and clear the channel counter.
REQ-021 If wr_en and start occur in the same IDLE cycle, SHALL apply the write and SHALL use the written value in the computation.
REQ-022 In MAC, SHALL add signed x[k]*w[k] (2*DATA_W bits, sign-extended) to the accumulator once per cycle, with k = 0..len-1, then go to ACT.
REQ-023 In ACT, SHALL compute r = acc >>> FRAC_W (arithmetic shift), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then apply the activation of REQ-034/035.
REQ-024 In DONE, SHALL register the result into y, pulse done for exactly one cycle, and return to IDLE.
REQ-025 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge len+2.
REQ-026 busy SHALL be 1 in MAC, ACT and DONE, and 0 in IDLE.
REQ-027 hold SHALL equal busy OR (start AND state==IDLE), combinationally, so the CPU stalls from the request cycle until the cycle done is high.
REQ-028 While busy, SHALL ignore wr_en and start; registers and FSM SHALL be unaffected.
REQ-029 A start asserted in the DONE cycle SHALL be ignored; start SHALL be re-asserted in IDLE to begin again.
REQ-030 y SHALL change only in DONE.

Reset
REQ-031 rst low SHALL immediately force: state IDLE; busy, hold, done = 0; y = 0; accumulator = 0; counter = 0; all x, w = 0; bias = 0; len = 0.
REQ-032 rst asserted mid-computation SHALL abort it with no done pulse; y SHALL read 0 after reset.
REQ-033 Release of rst SHALL be synchronised by the integrator; the block SHALL take no action until the first edge with rst high.

Configuration
REQ-034 With macro DNN_RELU_EN defined, the activation SHALL be ReLU: a negative saturated r SHALL give y = 0, otherwise y = r.
REQ-035 Without DNN_RELU_EN, the activation SHALL be identity: y = saturated r, negatives passed through.

Verification
REQ-036 Setup for all cases: N_IN=4, DATA_W=16, FRAC_W=8, DNN_RELU_EN defined; x0..3 = 0x0100, w0..3 = 0x0080, bias 0, start -> done 6 cycles after start, y = 0x0200, hold high throughout.
REQ-037 Sign and ReLU: w0..3 = 0xFF80, bias 0x0040 -> y = 0x0000; same case without DNN_RELU_EN -> y = 0xFE40.
REQ-038 Saturation and len: x, w all 0x7FFF -> y = 0x7FFF; len = 2, x = 0x0100, w = 0x0100 -> y = 0x0200, done 4 cycles after start.
REQ-039 Busy protection: start and x0 write asserted 2 cycles after the first start -> ignored; result unchanged, single done pulse.
REQ-040 Reset mid-op: rst low 3 cycles after start -> busy = 0 immediately, no done, y = 0; a new computation after reset gives y = 0x0000 (registers cleared).
